// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: groups the raw PS/2 lines and the decoded key outputs.
`default_nettype none

interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic       left;
  logic       right;
  logic       down;
  logic       up;
  logic [3:0] key_held;

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, scan_valid, frame_err, left, right, down, up, key_held
  );

  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, scan_valid, frame_err, left, right, down, up, key_held
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receive-only PS/2 keyboard deframer and arrow-key decoder.
// Revision: 1.0
`default_nettype none

module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  ps2_key_decoder_if.slave    bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} frame_state_e;
  typedef enum logic [1:0] {BASE, EXT, BRK, EXTBRK} seq_state_e;

  logic [1:0]   clk_sync_q, data_sync_q;
  logic         filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  frame_state_e frame_q, frame_d;
  seq_state_e   seq_q, seq_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         parity_q, parity_d;
  logic         stop_q, stop_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]   scan_code_q, scan_code_d;
  logic         scan_valid_q, scan_valid_d;
  logic         frame_err_q, frame_err_d;
  logic [3:0]   strobe_q, strobe_d;
  logic [3:0]   held_q, held_d;
  logic         fall_w;
  logic         data_w;
  logic [3:0]   arrow_w;

  assign data_w = data_sync_q[1];

  // One-hot arrow decode in {up, down, right, left} order.
  always_comb begin
    arrow_w = 4'b0000;
    case (shift_q)
      8'h6B:   arrow_w = 4'b0001;
      8'h74:   arrow_w = 4'b0010;
      8'h72:   arrow_w = 4'b0100;
      8'h75:   arrow_w = 4'b1000;
      default: arrow_w = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      frame_q      <= IDLE;
      seq_q        <= BASE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      stop_q       <= 1'b0;
      to_cnt_q     <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      strobe_q     <= 4'b0000;
      held_q       <= 4'b0000;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], bus.ps2_clk};
      data_sync_q  <= {data_sync_q[0], bus.ps2_data};
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      frame_q      <= frame_d;
      seq_q        <= seq_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      stop_q       <= stop_d;
      to_cnt_q     <= to_cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      strobe_q     <= strobe_d;
      held_q       <= held_d;
    end
  end

  always_comb begin
    filt_d       = filt_q;
    filt_cnt_d   = '0;
    fall_w       = 1'b0;
    frame_d      = frame_q;
    seq_d        = seq_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    stop_d       = stop_q;
    to_cnt_d     = '0;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    strobe_d     = 4'b0000;
    held_d       = held_q;

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_sync_q[1];
        fall_w = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    case (frame_q)
      IDLE: begin
        if (fall_w) begin
          if (!data_w) begin
            frame_d   = SHIFT;
            bit_cnt_d = 4'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        // A fall wins over a simultaneous timeout.
        if (fall_w) begin
          if (bit_cnt_q < 4'd8) begin
            shift_d = {data_w, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            parity_d = data_w;
          end else begin
            stop_d  = data_w;
            frame_d = DONE;
          end
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (to_cnt_q == TO_LAST) begin
          frame_d     = IDLE;
          frame_err_d = 1'b1;
          seq_d       = BASE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE: begin
        frame_d = IDLE;
        if ((^{shift_q, parity_q}) && stop_q) begin
          scan_code_d  = shift_q;
          scan_valid_d = 1'b1;
          case (seq_q)
            BASE: begin
              if (shift_q == 8'hE0)      seq_d = EXT;
              else if (shift_q == 8'hF0) seq_d = BRK;
            end
            EXT: begin
              if (shift_q == 8'hF0) begin
                seq_d = EXTBRK;
              end else begin
                strobe_d = arrow_w;
                held_d   = held_q | arrow_w;
                seq_d    = BASE;
              end
            end
            EXTBRK: begin
              held_d = held_q & ~arrow_w;
              seq_d  = BASE;
            end
            default: seq_d = BASE;
          endcase
        end else begin
          frame_err_d = 1'b1;
          seq_d       = BASE;
        end
      end
      default: frame_d = IDLE;
    endcase
  end

  assign bus.scan_code  = scan_code_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.left       = strobe_q[0];
  assign bus.right      = strobe_q[1];
  assign bus.down       = strobe_q[2];
  assign bus.up         = strobe_q[3];
  assign bus.key_held   = held_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench driving PS/2 frames into ps2_key_decoder.
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_key_decoder;
  localparam int FILT = 8;
  localparam int TO   = 300;
  localparam int HP   = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs;
  logic [3:0]  strb;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign strb = {bus.up, bus.down, bus.right, bus.left};
  assign obs  = {bus.scan_valid, bus.frame_err, strb,
                 (bus.scan_valid ? bus.scan_code : 8'h00), bus.key_held};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic sv, input logic fe, input logic [3:0] st,
                      input logic [7:0] code, input logic [3:0] held);
    exp_q.push_back({sv, fe, st, code, held});
  endtask

  always @(negedge clk) begin
    if (!reset && (bus.scan_valid || bus.frame_err || (strb != 4'b0000))) begin
      if (exp_q.size() == 0) check("unexpected", 32'(obs), 32'h0);
      else                   check("event", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] code, input logic bad);
    logic par;
    par = bad ? (^code) : ~(^code);
    return {1'b1, par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      wait_cyc(HP / 2);
      bus.ps2_clk = 1'b0;
      wait_cyc(HP);
      bus.ps2_clk = 1'b1;
      wait_cyc(HP / 2);
    end
  endtask

  task automatic send_byte(input logic [7:0] code, input logic bad);
    send_bits(frame(code, bad), 11);
    wait_cyc(2 * HP);
  endtask

  task automatic chk_idle(input string tag);
    check(tag, {12'h0, bus.scan_code, bus.scan_valid, bus.frame_err, strb, bus.key_held}, 32'h0);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset        = 1'b1;
    wait_cyc(5);
    chk_idle("reset_state");
    reset = 1'b0;
    wait_cyc(20);
    chk_idle("post_reset");

    // E0 6B: left make
    push(1, 0, 4'b0000, 8'hE0, 4'b0000);
    push(1, 0, 4'b0001, 8'h6B, 4'b0001);
    send_byte(8'hE0, 0);
    send_byte(8'h6B, 0);
    check("left_code", 32'(bus.scan_code), 32'h6B);
    check("left_held", 32'(bus.key_held), 32'h1);

    // E0 F0 6B: left break
    push(1, 0, 4'b0000, 8'hE0, 4'b0001);
    push(1, 0, 4'b0000, 8'hF0, 4'b0001);
    push(1, 0, 4'b0000, 8'h6B, 4'b0000);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h6B, 0);
    check("brk_held", 32'(bus.key_held), 32'h0);

    // bad parity drops the extended prefix, then a good E0 74
    push(1, 0, 4'b0000, 8'hE0, 4'b0000);
    push(0, 1, 4'b0000, 8'h00, 4'b0000);
    push(1, 0, 4'b0000, 8'hE0, 4'b0000);
    push(1, 0, 4'b0010, 8'h74, 4'b0010);
    send_byte(8'hE0, 0);
    send_byte(8'h74, 1);
    check("par_code_hold", 32'(bus.scan_code), 32'hE0);
    send_byte(8'hE0, 0);
    send_byte(8'h74, 0);

    // timeout after start + 5 data bits, then E0 72
    push(0, 1, 4'b0000, 8'h00, 4'b0010);
    send_bits(frame(8'h72, 0), 6);
    wait_cyc(TO + 100);
    check("to_drain", exp_q.size(), 0);
    push(1, 0, 4'b0000, 8'hE0, 4'b0010);
    push(1, 0, 4'b0100, 8'h72, 4'b0110);
    send_byte(8'hE0, 0);
    send_byte(8'h72, 0);
    check("down_held", 32'(bus.key_held), 32'h6);

    // short low glitch while idle
    bus.ps2_clk = 1'b0;
    wait_cyc(3);
    bus.ps2_clk = 1'b1;
    wait_cyc(60);
    check("glitch_code", 32'(bus.scan_code), 32'h72);

    // reset in the middle of F0 after E0
    push(1, 0, 4'b0000, 8'hE0, 4'b0110);
    send_byte(8'hE0, 0);
    send_bits(frame(8'hF0, 0), 5);
    reset = 1'b1;
    wait_cyc(2);
    chk_idle("in_reset");
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2 * HP);
    chk_idle("after_reset");
    push(1, 0, 4'b0000, 8'hE0, 4'b0000);
    push(1, 0, 4'b1000, 8'h75, 4'b1000);
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);

    // typematic repeat
    push(1, 0, 4'b0000, 8'hE0, 4'b1000);
    push(1, 0, 4'b1000, 8'h75, 4'b1000);
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    check("up_held", 32'(bus.key_held), 32'h8);

    wait_cyc(50);
    check("final_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
